// File: rtl/exp_align_if.sv
// Operand/result handshake bundle for the FP-adder exponent-align front end.
// The slave side is the aligner. The master side is whoever feeds operands and accepts results.
interface exp_align_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int AW = MAN_W + 4;

    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] in_exp_a;
    logic [MAN_W-1:0] in_man_a;
    logic [EXP_W-1:0] in_exp_b;
    logic [MAN_W-1:0] in_man_b;

    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] out_exp_max;
    logic [EXP_W-1:0] out_diff;
    logic             out_swap;
    logic             out_eq;
    logic             out_special;
    logic [AW-1:0]    out_man_big;
    logic [AW-1:0]    out_man_sml;

    modport slave (
        input  in_valid, in_exp_a, in_man_a, in_exp_b, in_man_b,
        output in_ready,
        output out_valid, out_exp_max, out_diff, out_swap, out_eq, out_special,
        output out_man_big, out_man_sml,
        input  out_ready
    );

    modport master (
        output in_valid, in_exp_a, in_man_a, in_exp_b, in_man_b,
        input  in_ready,
        input  out_valid, out_exp_max, out_diff, out_swap, out_eq, out_special,
        input  out_man_big, out_man_sml,
        output out_ready
    );
endinterface

// File: rtl/exp_align_pipe.sv
// Two-stage exponent compare / mantissa alignment front end for the FP adder.
// Stage 1 orders the operands by magnitude and computes the exponent difference.
// Stage 2 right-shifts the small mantissa by that difference, folding every lost bit into a sticky LSB.
module exp_align_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    exp_align_if.slave  bus
);
    localparam int AW     = MAN_W + 4;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [EXP_W-1:0] exp_max;
        logic [EXP_W-1:0] diff;
        logic             swap;
        logic             eq;
        logic             special;
        logic [AW-1:0]    man_big;
        logic [AW-1:0]    man_sml;
    } stage_t;

    // vld_pipe_q[0]: stage-1 register holds a pair, vld_pipe_q[1]: output register holds a result
    logic [STAGES-1:0] vld_pipe_q;
    stage_t            s1_q, s1_d;
    stage_t            s2_q, s2_d;
    logic              s1_load, s2_load;

    // A stage may load when it is empty or its content leaves this cycle
    assign s2_load      = !vld_pipe_q[1] | bus.out_ready;
    assign s1_load      = !vld_pipe_q[0] | s2_load;
    assign bus.in_ready = s1_load;

    // Stage 1: effective exponents, magnitude ordering and exponent difference
    logic             hid_a, hid_b;
    logic [EXP_W-1:0] eff_a, eff_b;
    logic [AW-1:0]    ext_a, ext_b;
    logic             swap;
    always_comb begin
        hid_a = |bus.in_exp_a;
        hid_b = |bus.in_exp_b;
        // Denormals share the alignment point of exponent 1
        eff_a = hid_a ? bus.in_exp_a : EXP_W'(1);
        eff_b = hid_b ? bus.in_exp_b : EXP_W'(1);
        ext_a = {hid_a, bus.in_man_a, 3'b000};
        ext_b = {hid_b, bus.in_man_b, 3'b000};
        // On equal exponents the larger {hidden,fraction} wins. Exact ties keep A as big.
        swap  = (eff_b > eff_a) | ((eff_a == eff_b) & (ext_b > ext_a));

        s1_d         = '0;
        s1_d.swap    = swap;
        s1_d.eq      = (eff_a == eff_b);
        s1_d.special = (&bus.in_exp_a) | (&bus.in_exp_b);
        s1_d.exp_max = swap ? eff_b : eff_a;
        s1_d.diff    = swap ? (eff_b - eff_a) : (eff_a - eff_b);
        s1_d.man_big = swap ? ext_b : ext_a;
        s1_d.man_sml = swap ? ext_a : ext_b;
    end

    // Stage 2: align the small mantissa with guard/round/sticky
    logic [AW-1:0] shifted, lost_mask;
    logic          sticky, too_far;
    always_comb begin
        s2_d      = s1_q;
        too_far   = (32'(s1_q.diff) >= 32'(AW));
        shifted   = s1_q.man_sml >> s1_q.diff;
        lost_mask = ~({AW{1'b1}} << s1_q.diff);
        sticky    = |(s1_q.man_sml & lost_mask);
        if (too_far)
            s2_d.man_sml = {{(AW-1){1'b0}}, |s1_q.man_sml};
        else
            s2_d.man_sml = {shifted[AW-1:1], shifted[0] | sticky};
    end

    // Valid shift chain and stage registers, advanced only where the downstream slot frees up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            if (s1_load)
                vld_pipe_q[0] <= bus.in_valid;
            if (bus.in_valid & s1_load)
                s1_q <= s1_d;
            if (s2_load)
                vld_pipe_q[1] <= vld_pipe_q[0];
            if (vld_pipe_q[0] & s2_load)
                s2_q <= s2_d;
        end
    end

    assign bus.out_valid   = vld_pipe_q[1];
    assign bus.out_exp_max = s2_q.exp_max;
    assign bus.out_diff    = s2_q.diff;
    assign bus.out_swap    = s2_q.swap;
    assign bus.out_eq      = s2_q.eq;
    assign bus.out_special = s2_q.special;
    assign bus.out_man_big = s2_q.man_big;
    assign bus.out_man_sml = s2_q.man_sml;
endmodule

// File: tb/tb_exp_align_pipe.sv
// Scoreboard bench for exp_align_pipe (EXP_W=8, MAN_W=23, AW=27).
// The driver pushes the hand-computed result of each accepted pair. The monitor pops on every
// output transfer and also checks that a stalled output does not change.
module tb_exp_align_pipe;
    typedef struct packed {
        logic [7:0]  exp_max;
        logic [7:0]  diff;
        logic        swap;
        logic        eq;
        logic        special;
        logic [26:0] big;
        logic [26:0] sml;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exp_align_if #(.EXP_W(8), .MAN_W(23)) bus ();
    exp_align_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_in   = 0;
    int   n_out  = 0;

    function automatic res_t mk(input int em, input int d, input bit sw, input bit eq, input bit sp,
                                input logic [26:0] big, input logic [26:0] sml);
        res_t r;
        r.exp_max = 8'(em);
        r.diff    = 8'(d);
        r.swap    = sw;
        r.eq      = eq;
        r.special = sp;
        r.big     = big;
        r.sml     = sml;
        return r;
    endfunction

    function automatic res_t got();
        res_t r;
        r.exp_max = bus.out_exp_max;
        r.diff    = bus.out_diff;
        r.swap    = bus.out_swap;
        r.eq      = bus.out_eq;
        r.special = bus.out_special;
        r.big     = bus.out_man_big;
        r.sml     = bus.out_man_sml;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string name, input res_t a, input res_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got max=%0d diff=%0d swap=%0b eq=%0b sp=%0b big=%h sml=%h expected max=%0d diff=%0d swap=%0b eq=%0b sp=%0b big=%h sml=%h",
                     name, a.exp_max, a.diff, a.swap, a.eq, a.special, a.big, a.sml,
                     e.exp_max, e.diff, e.swap, e.eq, e.special, e.big, e.sml);
        end
    endtask

    // Monitor: compare every transfer against the scoreboard, and check stability under stall
    res_t held;
    bit   stalled = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk_res("stall_stable", got(), held);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got max=%0d sml=%h expected no output",
                             bus.out_exp_max, bus.out_man_sml);
                end else begin
                    chk_res("result", got(), exp_q.pop_front());
                end
                n_out++;
                stalled = 1'b0;
            end else if (bus.out_valid) begin
                held    = got();
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [7:0] ea, input logic [22:0] ma,
                        input logic [7:0] eb, input logic [22:0] mb, input res_t e);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_exp_a = ea;
        bus.in_man_a = ma;
        bus.in_exp_b = eb;
        bus.in_man_b = mb;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
        end else begin
            @(posedge clk);
            exp_q.push_back(e);
            n_in++;
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    int in0, out0;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_exp_a  = '0;
        bus.in_man_a  = '0;
        bus.in_exp_b  = '0;
        bus.in_man_b  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_outputs", 32'(|got()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back to back
        send(8'd127, 23'd0, 8'd126, 23'd0, mk(127, 1, 0, 0, 0, 27'h4000000, 27'h2000000));
        send(8'd0, 23'd1, 8'd1, 23'd0, mk(1, 0, 1, 1, 0, 27'h4000000, 27'h0000008));
        send(8'd100, 23'd1, 8'd150, 23'd0, mk(150, 50, 1, 0, 0, 27'h4000000, 27'h0000001));
        send(8'd130, 23'd0, 8'd126, 23'd1, mk(130, 4, 0, 0, 0, 27'h4000000, 27'h0400001));
        send(8'd255, 23'd0, 8'd126, 23'd1, mk(255, 129, 0, 0, 1, 27'h4000000, 27'h0000001));
        send(8'd10, 23'd5, 8'd10, 23'd5, mk(10, 0, 0, 1, 0, 27'h4000028, 27'h4000028));
        send(8'd0, 23'd0, 8'd0, 23'd0, mk(1, 0, 0, 1, 0, 27'h0000000, 27'h0000000));
        send(8'd130, 23'd0, 8'd127, 23'h7FFFFF, mk(130, 3, 0, 0, 0, 27'h4000000, 27'h0FFFFFF));
        send(8'd130, 23'd0, 8'd125, 23'h7FFFFF, mk(130, 5, 0, 0, 0, 27'h4000000, 27'h03FFFFF));
        send(8'd50, 23'd1, 8'd50, 23'd2, mk(50, 0, 1, 1, 0, 27'h4000010, 27'h4000008));
        send(8'd3, 23'd0, 8'd255, 23'd7, mk(255, 252, 1, 0, 1, 27'h4000038, 27'h0000001));
        send(8'd127, 23'd0, 8'd102, 23'd0, mk(127, 25, 0, 0, 0, 27'h4000000, 27'h0000002));
        send(8'd127, 23'd0, 8'd101, 23'd0, mk(127, 26, 0, 0, 0, 27'h4000000, 27'h0000001));
        send(8'd127, 23'd0, 8'd100, 23'd0, mk(127, 27, 0, 0, 0, 27'h4000000, 27'h0000001));
        send(8'd255, 23'd0, 8'd255, 23'd1, mk(255, 0, 1, 1, 1, 27'h4000008, 27'h4000000));
        drain();

        // Backpressure: 4 pairs with out_ready held low for a few cycles
        in0 = n_in;
        out0 = n_out;
        bus.out_ready = 1'b0;
        fork
            begin
                send(8'd127, 23'd0, 8'd126, 23'd0, mk(127, 1, 0, 0, 0, 27'h4000000, 27'h2000000));
                send(8'd130, 23'd0, 8'd126, 23'd1, mk(130, 4, 0, 0, 0, 27'h4000000, 27'h0400001));
                send(8'd0, 23'd1, 8'd1, 23'd0, mk(1, 0, 1, 1, 0, 27'h4000000, 27'h0000008));
                send(8'd50, 23'd1, 8'd50, 23'd2, mk(50, 0, 1, 1, 0, 27'h4000010, 27'h4000008));
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
                chk("stall_accepted", 32'(n_in - in0), 32'd2);
                chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", 32'(n_out - out0), 32'd4);

        // Reset with two pairs in flight
        bus.out_ready = 1'b0;
        send(8'd100, 23'd1, 8'd150, 23'd0, mk(150, 50, 1, 0, 0, 27'h4000000, 27'h0000001));
        send(8'd10, 23'd5, 8'd10, 23'd5, mk(10, 0, 0, 1, 0, 27'h4000028, 27'h4000028));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midreset_outputs", 32'(|got()), 32'd0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_idle", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(8'd130, 23'd0, 8'd126, 23'd1, mk(130, 4, 0, 0, 0, 27'h4000000, 27'h0400001));
        @(negedge clk);
        chk("latency_cycle1", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("latency_cycle2", {31'd0, bus.out_valid}, 32'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
